// File: rtl/regfile_wport_sched.sv
// Write-port scheduler: two one-entry holding buffers share the register-file
// write port, issuing at most one write per cycle, oldest buffer first.
module regfile_wport_sched #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5,
   parameter int unsigned CW = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [AW-1:0] req0_sel,
   input  logic [DW-1:0] req0_data,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [AW-1:0] req1_sel,
   input  logic [DW-1:0] req1_data,
   input  logic          wblock,
   output logic          Wen,
   output logic [AW-1:0] Wsel,
   output logic [DW-1:0] Wdat,
   output logic [CW-1:0] wr_cnt
);

   logic          hv0_q, hv0_d, hv1_q, hv1_d;
   logic [AW-1:0] hsel0_q, hsel0_d, hsel1_q, hsel1_d;
   logic [DW-1:0] hdat0_q, hdat0_d, hdat1_q, hdat1_d;
   logic          old1_q, old1_d;
   logic          wen_q, wen_d;
   logic [AW-1:0] wsel_q, wsel_d;
   logic [DW-1:0] wdat_q, wdat_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          grant0, grant1, acc0, acc1, keep0, keep1;
   logic [AW-1:0] gsel;
   logic [DW-1:0] gdat;

   always_comb begin
      grant0     = !wblock && hv0_q && (!hv1_q || !old1_q);
      grant1     = !wblock && hv1_q && (!hv0_q || old1_q);
      req0_ready = !RST && (!hv0_q || grant0);
      req1_ready = !RST && (!hv1_q || grant1);
      acc0       = req0_valid && req0_ready;
      acc1       = req1_valid && req1_ready;
      keep0      = hv0_q && !grant0;
      keep1      = hv1_q && !grant1;

      hv0_d   = acc0 || keep0;
      hv1_d   = acc1 || keep1;
      hsel0_d = acc0 ? req0_sel  : hsel0_q;
      hdat0_d = acc0 ? req0_data : hdat0_q;
      hsel1_d = acc1 ? req1_sel  : hsel1_q;
      hdat1_d = acc1 ? req1_data : hdat1_q;

      // A buffer that stays held is older than one loaded beside it; a tie goes to req0.
      old1_d = old1_q;
      if (acc0 && acc1)       old1_d = 1'b0;
      else if (acc0 && keep1) old1_d = 1'b1;
      else if (acc1 && keep0) old1_d = 1'b0;

      gsel   = grant1 ? hsel1_q : hsel0_q;
      gdat   = grant1 ? hdat1_q : hdat0_q;
      wen_d  = (grant0 || grant1) && (gsel != '0);
      wsel_d = (grant0 || grant1) ? gsel : wsel_q;
      wdat_d = (grant0 || grant1) ? gdat : wdat_q;

      cnt_d = cnt_q;
      if (wen_d && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hv0_q   <= 1'b0;
         hv1_q   <= 1'b0;
         hsel0_q <= '0;
         hsel1_q <= '0;
         hdat0_q <= '0;
         hdat1_q <= '0;
         old1_q  <= 1'b0;
         wen_q   <= 1'b0;
         wsel_q  <= '0;
         wdat_q  <= '0;
         cnt_q   <= '0;
      end else begin
         hv0_q   <= hv0_d;
         hv1_q   <= hv1_d;
         hsel0_q <= hsel0_d;
         hsel1_q <= hsel1_d;
         hdat0_q <= hdat0_d;
         hdat1_q <= hdat1_d;
         old1_q  <= old1_d;
         wen_q   <= wen_d;
         wsel_q  <= wsel_d;
         wdat_q  <= wdat_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Wen    = wen_q;
   assign Wsel   = wsel_q;
   assign Wdat   = wdat_q;
   assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wport_sched.sv
// Scoreboard bench: a queue model of accepted writes predicts readiness and the
// exact sequence of write-port pulses; a negedge monitor checks the port.
module tb_regfile_wport_sched;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0, wblock = 1'b0;
   logic          req0_ready, req1_ready;
   logic [AW-1:0] req0_sel = '0, req1_sel = '0;
   logic [DW-1:0] req0_data = '0, req1_data = '0;
   logic          Wen;
   logic [AW-1:0] Wsel;
   logic [DW-1:0] Wdat;
   logic [CW-1:0] wr_cnt;

   regfile_wport_sched #(.DW(DW), .AW(AW), .CW(CW)) dut (
      .CLK(CLK), .RST(RST),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_sel(req0_sel), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_sel(req1_sel), .req1_data(req1_data),
      .wblock(wblock), .Wen(Wen), .Wsel(Wsel), .Wdat(Wdat), .wr_cnt(wr_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic          r;
      logic [AW-1:0] sel;
      logic [DW-1:0] dat;
   } item_t;

   item_t mq[$];   // pending writes in acceptance order (at most one per requester)
   item_t sb[$];   // expected write pulses, popped by the monitor
   int    checks = 0;
   int    failures = 0;
   int    mon_cnt = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit holds(input logic r);
      foreach (mq[i]) if (mq[i].r == r) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: each expected pulse must appear on the first negedge after it was issued.
   always @(negedge CLK) begin
      if (RST) begin
         sb.delete();
         mon_cnt = 0;
         chk("wen_in_reset", Wen, 0);
      end else begin
         if (sb.size() > 0) begin
            item_t e;
            e = sb.pop_front();
            chk("wen", Wen, 1);
            chk("wsel", Wsel, e.sel);
            chk("wdat", Wdat, e.dat);
            if (mon_cnt < (1 << CW) - 1) mon_cnt++;
         end else begin
            chk("wen_idle", Wen, 0);
         end
         chk("wr_cnt", wr_cnt, mon_cnt);
      end
   end

   // One cycle: drive at negedge+1, predict, then advance to the next negedge+1.
   task automatic cyc(input logic v0, input logic [AW-1:0] s0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] s1, input logic [DW-1:0] d1,
                      input logic blk);
      bit g, r0, r1;
      item_t it;
      req0_valid = v0; req0_sel = s0; req0_data = d0;
      req1_valid = v1; req1_sel = s1; req1_data = d1;
      wblock = blk;
      #1;
      g  = !blk && (mq.size() > 0);
      r0 = !holds(1'b0) || (g && mq[0].r == 1'b0);
      r1 = !holds(1'b1) || (g && mq[0].r == 1'b1);
      chk("ready0", req0_ready, r0);
      chk("ready1", req1_ready, r1);
      if (g) begin
         it = mq.pop_front();
         if (it.sel != '0) sb.push_back(it);
      end
      if (v0 && r0) begin it.r = 1'b0; it.sel = s0; it.dat = d0; mq.push_back(it); end
      if (v1 && r1) begin it.r = 1'b1; it.sel = s1; it.dat = d1; mq.push_back(it); end
      @(negedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      @(negedge CLK); #1;
      chk("rst_wen", Wen, 0);
      chk("rst_wsel", Wsel, 0);
      chk("rst_wdat", Wdat, 0);
      chk("rst_cnt", wr_cnt, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      @(negedge CLK); #1;
      RST = 1'b0;

      // Single write.
      cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
      idle(3);
      // Age order: req1 held under wblock, then req0 to the same register.
      cyc(1'b0, '0, '0, 1'b1, 5'd3, 32'h11, 1'b1);
      cyc(1'b1, 5'd3, 32'h22, 1'b0, '0, '0, 1'b1);
      idle(4);
      // Same-cycle load, then continuous streaming.
      for (int i = 0; i < 8; i++) cyc(1'b1, 5'd7, 32'h700 + i, 1'b1, 5'd8, 32'h800 + i, 1'b0);
      idle(4);
      // Register 0 consumes without a pulse.
      cyc(1'b1, 5'd0, 32'hBAD0, 1'b0, '0, '0, 1'b0);
      idle(3);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 4) == 0);
      idle(4);
      chk("cnt_saturated", wr_cnt, (1 << CW) - 1);

      // Reset mid-stream with both buffers full and a pulse in flight.
      cyc(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 1'b1);
      cyc(1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hA6, 1'b0);
      chk("pre_rst_wen", Wen, 1);
      RST = 1'b1;
      #1;
      chk("arst_wen", Wen, 0);
      chk("arst_cnt", wr_cnt, 0);
      chk("arst_ready0", req0_ready, 0);
      chk("arst_ready1", req1_ready, 0);
      mq.delete();
      @(negedge CLK); #1;
      RST = 1'b0;
      idle(4);
      cyc(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
